dma_cmd_regfile_mc: RTL and testbench
=====================================

Name: dma_cmd_regfile_mc

Overview:
Parametrised APB register file for the DMA engine, with NUM_CH independent channels.
- Host direction: the host pushes 32-bit descriptor words into a per-channel command FIFO of depth DEPTH. The DMA core pops them.
- Core direction: the core pushes completion words into a per-channel done FIFO. The host pops them by reading a register.
- Overflow and underflow are reported through pslverr and through a maskable, write-1-to-clear interrupt.
- Sits between the APB interconnect and the DMA core.

Parameters:
- NUM_CH, 4, number of channels (1..16).
- DEPTH, 8, entries per FIFO; power of two, at least 2.
- BW_PADDR, 12, APB offset width; must be at least LOG2(NUM_CH)+5.
- BW_CNT, derived = LOG2(DEPTH)+1, occupancy count width.

Ports:
- clk  in  1  clock
- rstnn  in  1  asynchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB enable
- paddr  in  BW_PADDR  APB byte offset
- pwrite  in  1  APB write
- pwdata  in  32  APB write data
- prdata  out  32  APB read data
- pready  out  1  always 1
- pslverr  out  1  APB error
- cmd_rvalid  out  NUM_CH  command FIFO non-empty, per channel
- cmd_rdata  out  NUM_CH*32  head of each command FIFO; channel c at bits [32c+31:32c]
- cmd_rpop  in  NUM_CH  core pop of command FIFO, per channel
- done_push  in  NUM_CH  core push into done FIFO, per channel
- done_wdata  in  NUM_CH*32  done words, same packing as cmd_rdata
- done_full  out  NUM_CH  done FIFO full, per channel
- irq  out  1  registered interrupt

Behaviour:
- Reset (rstnn=0, async): all FIFOs empty, all counts 0, IRQ_PEND=0, IRQ_MASK=0, irq=0, cmd_rvalid=0, done_full=0, prdata=0, pslverr=0.
- APB access phase is psel&penable. Zero wait states. prdata and pslverr are combinational during the access phase and 0 otherwise.
- Address decode: paddr[BW_PADDR-1:5] = channel, paddr[4:2] = register index, paddr[1:0] ignored.
- A channel number at or above NUM_CH, or an unmapped register index, gives pslverr=1, prdata=0, and no side effect.
- Register map, per channel:
  - 0 CMD_PUSH (W): push pwdata into the command FIFO. Reads return 0.
  - 1 CMD_COUNT (R): command FIFO occupancy, zero-extended.
  - 2 DONE_POP (R): returns the head of the done FIFO and pops it in the same cycle.
  - 3 DONE_COUNT (R): done FIFO occupancy.
  - 4 IRQ_PEND (R/W1C): bit0 = done word arrived, bit1 = command overflow, bit2 = done overflow.
  - 5 IRQ_MASK (R/W): bits [2:0].
- Writes to read-only registers are ignored with pslverr=0.
- CMD_PUSH when the command FIFO is full (occupancy before the cycle = DEPTH):
  - Write dropped, pslverr=1.
  - IRQ_PEND bit1 set.
  - A same-cycle cmd_rpop does not rescue the push.
- DONE_POP when the done FIFO is empty: prdata=0, pslverr=1, no state change.
- FIFO push and pop in the same cycle (not full, not empty): occupancy unchanged, data order preserved.
- cmd_rpop while empty: ignored.
- done_push while full: word dropped, IRQ_PEND bit2 set.
- Every accepted done_push sets IRQ_PEND bit0.
- IRQ_PEND set and a W1C clear in the same cycle: set wins.
- irq is registered: irq <= OR over all channels of (IRQ_PEND & IRQ_MASK). It asserts one cycle after the pending or mask update.
- cmd_rvalid, cmd_rdata and done_full reflect registered FIFO state. A pushed word is visible on cmd_rdata the cycle after the push.
- FIFO storage uses read/write pointers of BW_CNT-1 bits that wrap modulo DEPTH, plus a BW_CNT-bit count.
- Channels are fully independent. No arbitration is needed, because APB touches at most one channel per cycle.

Optional Feature:
Macro: RVX_DMA_CMD_FLUSH_EN.
- Defined: register index 6 FLUSH (W) is decoded per channel.
  - Writing bit0=1 empties the command FIFO; writing bit1=1 empties the done FIFO, in the cycle after the write.
  - A same-cycle core push or pop on a flushed FIFO is discarded.
  - IRQ_PEND is unaffected.
- Not defined: index 6 is unmapped (pslverr=1). There is no flush logic.

Test Plan:
- Reset, then read CMD_COUNT and IRQ_PEND on ch0 -> 0 and 0, pslverr=0; after reset irq=0 and cmd_rvalid=0.
- NUM_CH=4, DEPTH=8: push 0x11..0x18 into ch2 CMD_PUSH -> CMD_COUNT=8.
  - 9th push gives pslverr=1 and IRQ_PEND[1]=1.
  - 8 cmd_rpop[2] pulses return 0x11..0x18 in order.
- Core done_push ch1 data 0xA5A5_0001 with IRQ_MASK ch1=1 -> irq=1 one cycle after the push.
  - DONE_POP returns 0xA5A5_0001.
  - A second DONE_POP gives pslverr=1, prdata=0.
  - Writing 1 to IRQ_PEND clears bit0 and irq drops the next cycle.
- Fill ch0 cmd to 7 entries, then CMD_PUSH and cmd_rpop in the same cycle -> count stays 7, pushed word becomes the last entry.
- Access channel 5 (NUM_CH=4) -> pslverr=1, no state change.
  - Assert rstnn=0 mid-burst -> all counts 0 immediately, irq=0.
- Flush macro defined: ch3 holds 5 commands, write FLUSH=1 -> CMD_COUNT=0 the next cycle.
  - Macro undefined: the same write gives pslverr=1.

Source files
------------

// File: rtl/dma_cmd_regfile_mc.sv
// dma_cmd_regfile_mc
// APB register file for the DMA engine with NUM_CH independent channels.
// Each channel owns a command FIFO (host pushes, DMA core pops) and a done
// FIFO (core pushes, host pops by reading DONE_POP). Overflow/underflow are
// reported on pslverr and through a maskable write-1-to-clear interrupt.
//
// Optional feature macro: RVX_DMA_CMD_FLUSH_EN
//   When defined, register index 6 (FLUSH) empties the command FIFO (bit0)
//   and/or the done FIFO (bit1). When undefined, index 6 is unmapped.
//
// Ports:
//   clk, rstnn                 clock, asynchronous active-low reset
//   psel/penable/paddr/pwrite  APB request (zero wait states)
//   pwdata/prdata              APB data; prdata is combinational in access phase
//   pready/pslverr             APB response (pready tied to 1)
//   cmd_rvalid/cmd_rdata       per-channel command FIFO head (registered state)
//   cmd_rpop                   per-channel core pop of the command FIFO
//   done_push/done_wdata       per-channel core push into the done FIFO
//   done_full                  per-channel done FIFO full
//   irq                        registered OR of (IRQ_PEND & IRQ_MASK)
module dma_cmd_regfile_mc #(
  parameter int NUM_CH   = 4,
  parameter int DEPTH    = 8,
  parameter int BW_PADDR = 12
) (
  input  logic                  clk,
  input  logic                  rstnn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic [BW_PADDR-1:0]   paddr,
  input  logic                  pwrite,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [NUM_CH-1:0]     cmd_rvalid,
  output logic [NUM_CH*32-1:0]  cmd_rdata,
  input  logic [NUM_CH-1:0]     cmd_rpop,
  input  logic [NUM_CH-1:0]     done_push,
  input  logic [NUM_CH*32-1:0]  done_wdata,
  output logic [NUM_CH-1:0]     done_full,
  output logic                  irq
);

  localparam int BW_CNT = $clog2(DEPTH) + 1;
  localparam int BW_PTR = BW_CNT - 1;
  localparam int BW_CH  = BW_PADDR - 5;
  localparam logic [BW_CNT-1:0] FULL_CNT = BW_CNT'(DEPTH);

  localparam logic [2:0] REG_CMD_PUSH   = 3'd0;
  localparam logic [2:0] REG_CMD_COUNT  = 3'd1;
  localparam logic [2:0] REG_DONE_POP   = 3'd2;
  localparam logic [2:0] REG_DONE_COUNT = 3'd3;
  localparam logic [2:0] REG_IRQ_PEND   = 3'd4;
  localparam logic [2:0] REG_IRQ_MASK   = 3'd5;
  localparam logic [2:0] REG_FLUSH      = 3'd6;

  logic             access;
  logic [BW_CH-1:0] ch_idx;
  logic [2:0]       reg_idx;
  logic             ch_ok;
  logic             reg_ok;
  logic             irq_any;
  logic             unused_paddr_lsbs;

  // Per-channel state gathered into packed views for the shared read mux.
  logic [NUM_CH-1:0][BW_CNT-1:0] cmd_cnt_v;
  logic [NUM_CH-1:0][BW_CNT-1:0] done_cnt_v;
  logic [NUM_CH-1:0][31:0]       done_head_v;
  logic [NUM_CH-1:0][2:0]        pend_v;
  logic [NUM_CH-1:0][2:0]        mask_v;

  assign access            = psel & penable;
  assign ch_idx            = paddr[BW_PADDR-1:5];
  assign reg_idx           = paddr[4:2];
  assign ch_ok             = (int'(ch_idx) < NUM_CH);
  assign pready            = 1'b1;
  assign unused_paddr_lsbs = ^paddr[1:0];

`ifdef RVX_DMA_CMD_FLUSH_EN
  assign reg_ok = (reg_idx <= REG_FLUSH);
`else
  assign reg_ok = (reg_idx <= REG_IRQ_MASK);
`endif

  // APB response: decode errors first, then per-register read data and the
  // full/empty error cases. Everything is zero outside the access phase.
  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    if (access) begin
      if (!ch_ok || !reg_ok) begin
        pslverr = 1'b1;
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_idx == BW_CH'(c)) begin
            case (reg_idx)
              REG_CMD_PUSH:   pslverr = pwrite && (cmd_cnt_v[c] == FULL_CNT);
              REG_CMD_COUNT:  if (!pwrite) prdata = 32'(cmd_cnt_v[c]);
              REG_DONE_POP: begin
                if (!pwrite) begin
                  if (done_cnt_v[c] == '0) pslverr = 1'b1;
                  else                     prdata  = done_head_v[c];
                end
              end
              REG_DONE_COUNT: if (!pwrite) prdata = 32'(done_cnt_v[c]);
              REG_IRQ_PEND:   if (!pwrite) prdata = 32'(pend_v[c]);
              REG_IRQ_MASK:   if (!pwrite) prdata = 32'(mask_v[c]);
              default: ;
            endcase
          end
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [31:0]       cmd_mem  [DEPTH];
    logic [31:0]       done_mem [DEPTH];
    logic [BW_PTR-1:0] cmd_wp, cmd_rp, done_wp, done_rp;
    logic [BW_CNT-1:0] cmd_cnt, done_cnt;
    logic [2:0]        pend, mask;
    logic              sel, cmd_full, cmd_empty, done_full_q, done_empty;
    logic              cmd_wr, cmd_push_ok, cmd_pop_ok, cmd_ovf;
    logic              done_pop_ok, done_push_ok, done_ovf;
    logic              flush_cmd, flush_done;
    logic [2:0]        pend_set, pend_clr;

    assign sel         = access & ch_ok & (ch_idx == BW_CH'(c));
    assign cmd_full    = (cmd_cnt == FULL_CNT);
    assign cmd_empty   = (cmd_cnt == '0);
    assign done_full_q = (done_cnt == FULL_CNT);
    assign done_empty  = (done_cnt == '0);

`ifdef RVX_DMA_CMD_FLUSH_EN
    assign flush_cmd  = sel & pwrite & (reg_idx == REG_FLUSH) & pwdata[0];
    assign flush_done = sel & pwrite & (reg_idx == REG_FLUSH) & pwdata[1];
`else
    assign flush_cmd  = 1'b0;
    assign flush_done = 1'b0;
`endif

    // Full/empty are judged on occupancy before the cycle, so a same-cycle
    // pop never rescues a push into a full FIFO.
    assign cmd_wr       = sel & pwrite & (reg_idx == REG_CMD_PUSH);
    assign cmd_push_ok  = cmd_wr & ~cmd_full;
    assign cmd_ovf      = cmd_wr & cmd_full;
    assign cmd_pop_ok   = cmd_rpop[c] & ~cmd_empty & ~flush_cmd;
    assign done_pop_ok  = sel & ~pwrite & (reg_idx == REG_DONE_POP) & ~done_empty;
    assign done_push_ok = done_push[c] & ~done_full_q & ~flush_done;
    assign done_ovf     = done_push[c] & done_full_q & ~flush_done;

    assign pend_set = {done_ovf, cmd_ovf, done_push_ok};
    assign pend_clr = (sel & pwrite & (reg_idx == REG_IRQ_PEND)) ? pwdata[2:0] : 3'b000;

    // Command FIFO pointers and occupancy; a flush overrides any core traffic.
    always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
        cmd_wp  <= '0;
        cmd_rp  <= '0;
        cmd_cnt <= '0;
      end else if (flush_cmd) begin
        cmd_wp  <= '0;
        cmd_rp  <= '0;
        cmd_cnt <= '0;
      end else begin
        if (cmd_push_ok) cmd_wp <= cmd_wp + BW_PTR'(1);
        if (cmd_pop_ok)  cmd_rp <= cmd_rp + BW_PTR'(1);
        case ({cmd_push_ok, cmd_pop_ok})
          2'b10:   cmd_cnt <= cmd_cnt + BW_CNT'(1);
          2'b01:   cmd_cnt <= cmd_cnt - BW_CNT'(1);
          default: ;
        endcase
      end
    end

    // Done FIFO pointers and occupancy; the host pop comes from DONE_POP reads.
    always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
        done_wp  <= '0;
        done_rp  <= '0;
        done_cnt <= '0;
      end else if (flush_done) begin
        done_wp  <= '0;
        done_rp  <= '0;
        done_cnt <= '0;
      end else begin
        if (done_push_ok) done_wp <= done_wp + BW_PTR'(1);
        if (done_pop_ok)  done_rp <= done_rp + BW_PTR'(1);
        case ({done_push_ok, done_pop_ok})
          2'b10:   done_cnt <= done_cnt + BW_CNT'(1);
          2'b01:   done_cnt <= done_cnt - BW_CNT'(1);
          default: ;
        endcase
      end
    end

    // Storage is not reset; only entries between the pointers are ever observed.
    always_ff @(posedge clk) begin
      if (cmd_push_ok)  cmd_mem[cmd_wp]   <= pwdata;
      if (done_push_ok) done_mem[done_wp] <= done_wdata[32*c +: 32];
    end

    // Interrupt pending/mask; a new event beats a same-cycle W1C of that bit.
    always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
        pend <= '0;
        mask <= '0;
      end else begin
        pend <= (pend & ~pend_clr) | pend_set;
        if (sel & pwrite & (reg_idx == REG_IRQ_MASK)) mask <= pwdata[2:0];
      end
    end

    assign cmd_rvalid[c]          = ~cmd_empty;
    assign cmd_rdata[32*c +: 32]  = cmd_mem[cmd_rp];
    assign done_full[c]           = done_full_q;
    assign cmd_cnt_v[c]           = cmd_cnt;
    assign done_cnt_v[c]          = done_cnt;
    assign done_head_v[c]         = done_mem[done_rp];
    assign pend_v[c]              = pend;
    assign mask_v[c]              = mask;
  end

  assign irq_any = |(pend_v & mask_v);

  // irq lags the pending/mask state by one cycle.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) irq <= 1'b0;
    else        irq <= irq_any;
  end

endmodule

// File: tb/tb_dma_cmd_regfile_mc.sv
// tb_dma_cmd_regfile_mc
// Self-checking bench for dma_cmd_regfile_mc (NUM_CH=4, DEPTH=8).
// A queue-based model of every channel tracks expected FIFO contents,
// interrupt state and APB responses; a negedge process compares the DUT to
// it each cycle, and directed sequences pin literal expected values.
// Honors RVX_DMA_CMD_FLUSH_EN to match the build of the design.
module tb_dma_cmd_regfile_mc;
  localparam int NUM_CH   = 4;
  localparam int DEPTH    = 8;
  localparam int BW_PADDR = 12;

  logic                  clk;
  logic                  rstnn;
  logic                  psel, penable, pwrite;
  logic [BW_PADDR-1:0]   paddr;
  logic [31:0]           pwdata, prdata;
  logic                  pready, pslverr;
  logic [NUM_CH-1:0]     cmd_rvalid, cmd_rpop, done_push, done_full;
  logic [NUM_CH*32-1:0]  cmd_rdata, done_wdata;
  logic                  irq;

  int total = 0;
  int bad   = 0;

  dma_cmd_regfile_mc #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .BW_PADDR(BW_PADDR)) dut (
    .clk(clk), .rstnn(rstnn),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .cmd_rvalid(cmd_rvalid), .cmd_rdata(cmd_rdata), .cmd_rpop(cmd_rpop),
    .done_push(done_push), .done_wdata(done_wdata), .done_full(done_full),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain queues per channel plus pending/mask words.
  logic [31:0] m_cmd  [NUM_CH][$];
  logic [31:0] m_done [NUM_CH][$];
  logic [2:0]  m_pend [NUM_CH];
  logic [2:0]  m_mask [NUM_CH];
  logic        m_irq;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected APB response from the register map rules and the model state.
  function automatic void exp_apb(output logic [31:0] rd, output logic err);
    int ch, idx;
    rd  = '0;
    err = 1'b0;
    if (!(psel && penable)) return;
    ch  = int'(paddr[BW_PADDR-1:5]);
    idx = int'(paddr[4:2]);
    if (ch >= NUM_CH) begin
      err = 1'b1;
      return;
    end
    case (idx)
      0: err = pwrite && (m_cmd[ch].size() == DEPTH);
      1: if (!pwrite) rd = m_cmd[ch].size();
      2: if (!pwrite) begin
           if (m_done[ch].size() == 0) err = 1'b1;
           else                        rd  = m_done[ch][0];
         end
      3: if (!pwrite) rd = m_done[ch].size();
      4: if (!pwrite) rd = {29'b0, m_pend[ch]};
      5: if (!pwrite) rd = {29'b0, m_mask[ch]};
`ifdef RVX_DMA_CMD_FLUSH_EN
      6: ;
`else
      6: err = 1'b1;
`endif
      default: err = 1'b1;
    endcase
  endfunction

  // Model state update at each clock edge from the inputs present then.
  always @(posedge clk or negedge rstnn) begin
    int ch, idx, csz, dsz;
    bit acc, sel, fl_c, fl_d, any;
    logic [2:0] set, clr;
    if (!rstnn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_cmd[c].delete();
        m_done[c].delete();
        m_pend[c] = '0;
        m_mask[c] = '0;
      end
      m_irq = 1'b0;
    end else begin
      any = 0;
      for (int c = 0; c < NUM_CH; c++) if ((m_pend[c] & m_mask[c]) != 0) any = 1;
      acc = psel && penable;
      ch  = int'(paddr[BW_PADDR-1:5]);
      idx = int'(paddr[4:2]);
      for (int c = 0; c < NUM_CH; c++) begin
        csz  = m_cmd[c].size();
        dsz  = m_done[c].size();
        sel  = acc && (ch == c);
        fl_c = 0;
        fl_d = 0;
`ifdef RVX_DMA_CMD_FLUSH_EN
        fl_c = sel && pwrite && (idx == 6) && pwdata[0];
        fl_d = sel && pwrite && (idx == 6) && pwdata[1];
`endif
        set = '0;
        clr = '0;
        if (cmd_rpop[c] && csz > 0) void'(m_cmd[c].pop_front());
        if (sel && pwrite && idx == 0) begin
          if (csz < DEPTH) m_cmd[c].push_back(pwdata);
          else             set[1] = 1'b1;
        end
        if (fl_c) m_cmd[c].delete();
        if (sel && !pwrite && idx == 2 && dsz > 0) void'(m_done[c].pop_front());
        if (done_push[c] && !fl_d) begin
          if (dsz < DEPTH) begin
            m_done[c].push_back(done_wdata[32*c +: 32]);
            set[0] = 1'b1;
          end else begin
            set[2] = 1'b1;
          end
        end
        if (fl_d) m_done[c].delete();
        if (sel && pwrite && idx == 4) clr = pwdata[2:0];
        if (sel && pwrite && idx == 5) m_mask[c] = pwdata[2:0];
        m_pend[c] = (m_pend[c] & ~clr) | set;
      end
      m_irq = any;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [31:0] erd;
    logic        eerr;
    exp_apb(erd, eerr);
    checkOutput("prdata", prdata, erd);
    checkOutput("pslverr", {31'b0, pslverr}, {31'b0, eerr});
    checkOutput("pready", {31'b0, pready}, 32'd1);
    checkOutput("irq", {31'b0, irq}, {31'b0, m_irq});
    for (int c = 0; c < NUM_CH; c++) begin
      checkOutput($sformatf("cmd_rvalid[%0d]", c), {31'b0, cmd_rvalid[c]},
                  {31'b0, m_cmd[c].size() > 0});
      checkOutput($sformatf("done_full[%0d]", c), {31'b0, done_full[c]},
                  {31'b0, m_done[c].size() == DEPTH});
      if (m_cmd[c].size() > 0)
        checkOutput($sformatf("cmd_rdata[%0d]", c), cmd_rdata[32*c +: 32], m_cmd[c][0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One APB transfer (setup + access); pop drives cmd_rpop during access.
  task automatic applyStimulus(input bit wr, input logic [BW_PADDR-1:0] addr,
                               input logic [31:0] data, input logic [NUM_CH-1:0] pop,
                               output logic [31:0] rd, output logic err);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    tick();
    penable  = 1'b1;
    cmd_rpop = pop;
    @(negedge clk);
    rd  = prdata;
    err = pslverr;
    tick();
    psel     = 1'b0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    cmd_rpop = '0;
  endtask

  task automatic checkRead(input string name, input logic [BW_PADDR-1:0] addr,
                           input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    applyStimulus(1'b0, addr, 32'h0, '0, rd, err);
    checkOutput({name, " data"}, rd, exp_rd);
    checkOutput({name, " err"}, {31'b0, err}, {31'b0, exp_err});
  endtask

  task automatic doWrite(input string name, input logic [BW_PADDR-1:0] addr,
                         input logic [31:0] data, input logic [NUM_CH-1:0] pop,
                         input logic exp_err);
    logic [31:0] rd;
    logic        err;
    applyStimulus(1'b1, addr, data, pop, rd, err);
    checkOutput({name, " err"}, {31'b0, err}, {31'b0, exp_err});
  endtask

  task automatic corePushDone(input int ch, input logic [31:0] data);
    done_wdata[32*ch +: 32] = data;
    done_push[ch] = 1'b1;
    tick();
    done_push = '0;
  endtask

  initial begin
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    cmd_rpop = '0; done_push = '0; done_wdata = '0;
    rstnn = 1'b1;
    #1 rstnn = 1'b0;
    #1;
    checkOutput("reset irq", {31'b0, irq}, 32'd0);
    checkOutput("reset cmd_rvalid", {28'b0, cmd_rvalid}, 32'd0);
    checkOutput("reset done_full", {28'b0, done_full}, 32'd0);
    #20 rstnn = 1'b1;
    tick();

    $display("[TB] reset readback");
    checkRead("ch0 CMD_COUNT", 12'h004, 32'd0, 1'b0);
    checkRead("ch0 IRQ_PEND", 12'h010, 32'd0, 1'b0);

    $display("[TB] ch2 command FIFO fill and overflow");
    for (int i = 0; i < 8; i++) doWrite("ch2 push", 12'h040, 32'h11 + i, '0, 1'b0);
    checkRead("ch2 CMD_COUNT full", 12'h044, 32'd8, 1'b0);
    doWrite("ch2 9th push", 12'h040, 32'h19, '0, 1'b1);
    checkRead("ch2 IRQ_PEND ovf", 12'h050, 32'h2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("ch2 head", cmd_rdata[95:64], 32'h11 + i);
      cmd_rpop = 4'b0100;
      tick();
      cmd_rpop = '0;
    end
    checkOutput("ch2 drained", {31'b0, cmd_rvalid[2]}, 32'd0);
    doWrite("ch2 W1C", 12'h050, 32'h2, '0, 1'b0);
    checkRead("ch2 IRQ_PEND cleared", 12'h050, 32'd0, 1'b0);

    $display("[TB] ch1 done word and irq");
    doWrite("ch1 mask", 12'h034, 32'h1, '0, 1'b0);
    corePushDone(1, 32'hA5A5_0001);
    checkOutput("irq not yet", {31'b0, irq}, 32'd0);
    tick();
    checkOutput("irq asserted", {31'b0, irq}, 32'd1);
    checkRead("ch1 DONE_POP", 12'h028, 32'hA5A5_0001, 1'b0);
    checkRead("ch1 DONE_POP empty", 12'h028, 32'd0, 1'b1);
    doWrite("ch1 W1C done", 12'h030, 32'h1, '0, 1'b0);
    checkOutput("irq lagging", {31'b0, irq}, 32'd1);
    tick();
    checkOutput("irq dropped", {31'b0, irq}, 32'd0);

    $display("[TB] ch0 push with same-cycle pop");
    for (int i = 0; i < 7; i++) doWrite("ch0 push", 12'h000, 32'h100 + i, '0, 1'b0);
    doWrite("ch0 push+pop", 12'h000, 32'h1FF, 4'b0001, 1'b0);
    checkRead("ch0 CMD_COUNT", 12'h004, 32'd7, 1'b0);
    for (int i = 0; i < 7; i++) begin
      checkOutput("ch0 order", cmd_rdata[31:0], (i < 6) ? 32'h101 + i : 32'h1FF);
      cmd_rpop = 4'b0001;
      tick();
      cmd_rpop = '0;
    end

    $display("[TB] ch0 done FIFO overflow");
    for (int i = 0; i < 8; i++) corePushDone(0, 32'hD000 + i);
    checkOutput("ch0 done_full", {31'b0, done_full[0]}, 32'd1);
    corePushDone(0, 32'hDEAD);
    checkRead("ch0 DONE_COUNT", 12'h00C, 32'd8, 1'b0);
    checkRead("ch0 IRQ_PEND", 12'h010, 32'h5, 1'b0);
    checkRead("ch0 DONE_POP", 12'h008, 32'hD000, 1'b0);
    checkRead("ch0 DONE_COUNT after pop", 12'h00C, 32'd7, 1'b0);
    doWrite("ch0 W1C", 12'h010, 32'h7, '0, 1'b0);

    $display("[TB] decode errors");
    doWrite("ch5 push", 12'h0A0, 32'hDEAD, '0, 1'b1);
    checkRead("ch5 CMD_COUNT", 12'h0A4, 32'd0, 1'b1);
    doWrite("ch5 mask", 12'h0B4, 32'h7, '0, 1'b1);
    checkRead("ch0 reg7", 12'h01C, 32'd0, 1'b1);
    doWrite("ch0 write CMD_COUNT", 12'h004, 32'h5, '0, 1'b0);
    checkRead("ch0 CMD_COUNT untouched", 12'h004, 32'd0, 1'b0);

    $display("[TB] ch3 flush");
    for (int i = 0; i < 5; i++) doWrite("ch3 push", 12'h060, 32'h300 + i, '0, 1'b0);
`ifdef RVX_DMA_CMD_FLUSH_EN
    doWrite("ch3 FLUSH", 12'h078, 32'h1, '0, 1'b0);
    checkRead("ch3 CMD_COUNT flushed", 12'h064, 32'd0, 1'b0);
`else
    doWrite("ch3 FLUSH unmapped", 12'h078, 32'h1, '0, 1'b1);
    checkRead("ch3 CMD_COUNT kept", 12'h064, 32'd5, 1'b0);
`endif

    $display("[TB] reset mid-burst");
    corePushDone(1, 32'hB1);
    corePushDone(1, 32'hB2);
    tick();
    checkOutput("irq before reset", {31'b0, irq}, 32'd1);
    for (int i = 0; i < 3; i++) doWrite("ch0 burst", 12'h000, 32'h700 + i, '0, 1'b0);
    psel = 1'b1; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'h777; penable = 1'b0;
    tick();
    penable = 1'b1;
    #2 rstnn = 1'b0;
    #1;
    checkOutput("mid reset cmd_rvalid", {28'b0, cmd_rvalid}, 32'd0);
    checkOutput("mid reset done_full", {28'b0, done_full}, 32'd0);
    checkOutput("mid reset irq", {31'b0, irq}, 32'd0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    tick();
    #2 rstnn = 1'b1;
    tick();
    checkRead("post reset ch0 CMD_COUNT", 12'h004, 32'd0, 1'b0);
    checkRead("post reset ch1 DONE_COUNT", 12'h02C, 32'd0, 1'b0);
    checkRead("post reset ch1 IRQ_PEND", 12'h030, 32'd0, 1'b0);
    checkRead("post reset ch1 IRQ_MASK", 12'h034, 32'd0, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
